decision_engine_core: RTL and testbench

//  Threshold/hysteresis decision core that sits directly downstream of the mydecisionslave_2 AXI4-Lite register file.

---
 rtl/decision_pkg.sv | 36 +++
 rtl/decision_hold_timer.sv | 46 ++++
 rtl/decision_engine_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_decision_engine_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decision_pkg.sv
// ---------------------------------------------------------------------------
// decision_pkg
//   Shared definitions for the threshold/hysteresis decision core:
//   - state_t      : FSM state encoding, also reported in status[2:0]
//   - CTRL_*       : bit indices inside the CTRL register (slv_reg0)
//   - THRESH_*     : field positions inside the THRESH register (slv_reg2)
//   - STATUS_*     : field positions inside the status word (register 3)
// ---------------------------------------------------------------------------
package decision_pkg;

  // The encoding is software-visible through status[2:0] and must not change.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_PENDING  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  // CTRL register bits
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_INVERT = 1;

  // THRESH register fields: on_thr in the low half, off_thr in the high half
  localparam int THRESH_ON_LSB  = 0;
  localparam int THRESH_OFF_LSB = 16;

  // Status word layout
  localparam int STATUS_STATE_LSB = 0;
  localparam int STATUS_STATE_W   = 3;
  localparam int STATUS_ACT_BIT   = 3;
  localparam int STATUS_IRQ_BIT   = 4;
  localparam int STATUS_CNT_LSB   = 16;
  localparam int STATUS_CNT_W     = 16;

endpackage : decision_pkg

// File: rtl/decision_hold_timer.sv
// ---------------------------------------------------------------------------
// decision_hold_timer
//   Up-counter that measures how long the core has been in COOLDOWN.
//   Counting starts from zero after a clear and stops at HOLD_CYCLES-1, where
//   the done flag is raised and held until the next clear.
//
// Ports
//   i_clk    in   clock, rising edge
//   i_rst    in   asynchronous active-high reset
//   i_clear  in   synchronous clear to zero (takes priority over i_run)
//   i_run    in   count one cycle
//   o_done   out  count has reached HOLD_CYCLES-1
// ---------------------------------------------------------------------------
module decision_hold_timer #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_done
);

  // At least one bit so HOLD_CYCLES == 1 still produces a legal counter.
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_count;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_done) begin
      // Saturating at the terminal value avoids a wrap when HOLD_CYCLES is a
      // power of two and the owner has not cleared us yet.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = (r_count == HOLD_LAST);

endmodule : decision_hold_timer

// File: rtl/decision_engine_core.sv
// ---------------------------------------------------------------------------
// decision_engine_core
//   Threshold/hysteresis decision core behind the mydecisionslave_2 register
//   file. Each qualified sensor sample is compared against an activation
//   threshold (on_thr) and a release threshold (off_thr). DEBOUNCE_N
//   consecutive hits activate the actuator; a release sample starts a
//   cooldown of HOLD_CYCLES cycles during which the actuator stays on and a
//   new hit re-activates without counting a new event. Every fresh
//   activation raises a sticky interrupt and bumps a saturating event counter.
//
// Ports
//   ACLK          in   clock, all logic on the rising edge
//   ARESET        in   asynchronous active-high reset
//   cfg_ctrl      in   [0] enable, [1] invert (trigger on the low side)
//   cfg_thresh    in   [DATA_W-1:0] on_thr, [16+DATA_W-1:16] off_thr
//   sample_data   in   sensor sample, qualified by sample_valid
//   sample_valid  in   one-cycle strobe
//   irq_clear     in   one-cycle strobe, clears irq (a same-cycle set wins)
//   act_en        out  actuator enable (registered)
//   irq           out  sticky event interrupt (registered)
//   status        out  [2:0] state, [3] act_en, [4] irq, [31:16] event count
// ---------------------------------------------------------------------------
module decision_engine_core
  import decision_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEBOUNCE_N  = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [31:0]       cfg_ctrl,
  input  logic [31:0]       cfg_thresh,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              irq_clear,
  output logic              act_en,
  output logic              irq,
  output logic [31:0]       status
);

  // Wide enough to hold DEBOUNCE_N itself.
  localparam int DEB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_N - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             r_state;
  logic               r_act_en;
  logic               r_irq;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [CNT_W-1:0]   r_event_count;

  // -------------------------------------------------------------------------
  // Configuration decode
  // -------------------------------------------------------------------------
  logic              w_enable;
  logic              w_invert;
  logic [DATA_W-1:0] w_on_thr;
  logic [DATA_W-1:0] w_off_thr;
  logic [DATA_W-1:0] w_off_eff;
  logic              w_hit;
  logic              w_rel;
  logic              w_sample_hit;
  logic              w_sample_rel;
  logic              w_activate;
  logic              w_hold_clear;
  logic              w_hold_run;
  logic              w_hold_done;
  logic              w_unused;

  assign w_enable  = cfg_ctrl[CTRL_ENABLE];
  assign w_invert  = cfg_ctrl[CTRL_INVERT];
  assign w_on_thr  = cfg_thresh[THRESH_ON_LSB +: DATA_W];
  assign w_off_thr = cfg_thresh[THRESH_OFF_LSB +: DATA_W];

  // Remaining CTRL/THRESH bits are reserved.
  assign w_unused = ^{cfg_ctrl, cfg_thresh};

  // NOTE: every combinational output gets a default at the top of the block
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    // A release threshold on the wrong side of the activation threshold would
    // make hit and release overlap; pin it to on_thr so the band collapses
    // to a single point instead of inverting.
    w_off_eff = w_off_thr;
    w_hit     = 1'b0;
    w_rel     = 1'b0;
    if (w_invert) begin
      if (w_off_thr < w_on_thr) w_off_eff = w_on_thr;
      w_hit = (sample_data <= w_on_thr);
      w_rel = (sample_data >= w_off_eff);
    end else begin
      if (w_off_thr > w_on_thr) w_off_eff = w_on_thr;
      w_hit = (sample_data >= w_on_thr);
      w_rel = (sample_data <= w_off_eff);
    end
  end

  assign w_sample_hit = sample_valid && w_hit;
  assign w_sample_rel = sample_valid && w_rel;

  // A fresh activation: the hit that completes the debounce run. Only this
  // path counts an event; COOLDOWN re-entry is deliberately excluded.
  assign w_activate = w_enable && w_sample_hit &&
                      (((r_state == ST_ARMED) && (DEBOUNCE_N == 1)) ||
                       ((r_state == ST_PENDING) && (r_deb_cnt == DEB_LAST)));

  // -------------------------------------------------------------------------
  // Cooldown timer: held at zero outside COOLDOWN, so it always starts
  // counting from zero on entry.
  // -------------------------------------------------------------------------
  assign w_hold_clear = (r_state != ST_COOLDOWN) || !w_enable;
  assign w_hold_run   = (r_state == ST_COOLDOWN);

  decision_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_clear (w_hold_clear),
    .i_run   (w_hold_run),
    .o_done  (w_hold_done)
  );

  // -------------------------------------------------------------------------
  // Decision FSM with registered actuator output and inline debounce count
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_act_en  <= 1'b0;
      r_deb_cnt <= '0;
    end else if (!w_enable) begin
      // Disable is a soft stop from any state; irq and the event count are
      // kept so software can still inspect what happened.
      r_state   <= ST_IDLE;
      r_act_en  <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARMED;
        end

        ST_ARMED: begin
          if (w_sample_hit) begin
            if (w_activate) begin
              r_state   <= ST_ACTIVE;
              r_act_en  <= 1'b1;
              r_deb_cnt <= '0;
            end else begin
              r_state   <= ST_PENDING;
              r_deb_cnt <= DEB_W'(1);
            end
          end
        end

        ST_PENDING: begin
          if (sample_valid) begin
            if (!w_hit) begin
              // Any miss breaks the run; start over.
              r_state   <= ST_ARMED;
              r_deb_cnt <= '0;
            end else if (w_activate) begin
              r_state   <= ST_ACTIVE;
              r_act_en  <= 1'b1;
              r_deb_cnt <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end
        end

        ST_ACTIVE: begin
          if (w_sample_rel) begin
            r_state <= ST_COOLDOWN;
          end
        end

        ST_COOLDOWN: begin
          // A hit outranks hold expiry in the same cycle.
          if (w_sample_hit) begin
            r_state <= ST_ACTIVE;
          end else if (w_hold_done) begin
            r_state  <= ST_ARMED;
            r_act_en <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_act_en  <= 1'b0;
          r_deb_cnt <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sticky interrupt and saturating event counter
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_irq         <= 1'b0;
      r_event_count <= '0;
    end else begin
      if (w_activate) begin
        r_irq <= 1'b1;
        if (r_event_count != {CNT_W{1'b1}}) begin
          r_event_count <= r_event_count + 1'b1;
        end
      end else if (irq_clear) begin
        r_irq <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: every status bit is a flop output or a constant zero.
  // -------------------------------------------------------------------------
  logic [STATUS_CNT_W-1:0] w_cnt_field;
  logic [31:0]             w_status;

  assign w_cnt_field = STATUS_CNT_W'(r_event_count);

  always_comb begin
    w_status = '0;
    w_status[STATUS_STATE_LSB +: STATUS_STATE_W] = r_state;
    w_status[STATUS_ACT_BIT]                      = r_act_en;
    w_status[STATUS_IRQ_BIT]                      = r_irq;
    w_status[STATUS_CNT_LSB +: STATUS_CNT_W]      = w_cnt_field;
  end

  assign act_en = r_act_en;
  assign irq    = r_irq;
  assign status = w_status;

endmodule : decision_engine_core

// File: tb/tb_decision_engine_core.sv
// ---------------------------------------------------------------------------
// tb_decision_engine_core
//   Directed table of vectors, hand-written multi-cycle sequences and a
//   randomized run compared against a behavioural model of the decision rules.
// ---------------------------------------------------------------------------
module tb_decision_engine_core;

  localparam int DEB_N = 4;
  localparam int HOLD  = 8;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] cfg_ctrl;
  logic [31:0] cfg_thresh;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        irq_clear;
  logic        act_en;
  logic        irq;
  logic [31:0] status;

  int n_pass  = 0;
  int n_total = 0;

  decision_engine_core #(
    .DATA_W      (16),
    .DEBOUNCE_N  (DEB_N),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .cfg_ctrl     (cfg_ctrl),
    .cfg_thresh   (cfg_thresh),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .irq_clear    (irq_clear),
    .act_en       (act_en),
    .irq          (irq),
    .status       (status)
  );

  always #5 ACLK = ~ACLK;

  // -------------------------------------------------------------------------
  // Behavioural model: tracks "running", "actuator on", length of the
  // current hit streak and age of the cooldown (-1 = not cooling down).
  // -------------------------------------------------------------------------
  bit m_run;
  bit m_active;
  int m_streak;
  int m_cool;
  bit m_irq;
  int m_count;

  task automatic model_reset();
    m_run = 0; m_active = 0; m_streak = 0; m_cool = -1; m_irq = 0; m_count = 0;
  endtask

  task automatic model_step();
    bit en, inv, hit, rel, set;
    int on_t, off_t, off_eff, d;
    en    = cfg_ctrl[0];
    inv   = cfg_ctrl[1];
    on_t  = int'(cfg_thresh[15:0]);
    off_t = int'(cfg_thresh[31:16]);
    d     = int'(sample_data);
    set   = 0;
    off_eff = off_t;
    if (!inv && off_t > on_t) off_eff = on_t;
    if (inv && off_t < on_t)  off_eff = on_t;
    hit = inv ? (d <= on_t) : (d >= on_t);
    rel = inv ? (d >= off_eff) : (d <= off_eff);
    if (!en) begin
      m_run = 0; m_active = 0; m_streak = 0; m_cool = -1;
    end else if (!m_run) begin
      m_run = 1;
    end else if (!m_active) begin
      if (sample_valid) begin
        if (hit) begin
          m_streak++;
          if (m_streak == DEB_N) begin
            m_active = 1; m_streak = 0; m_cool = -1; set = 1;
          end
        end else begin
          m_streak = 0;
        end
      end
    end else if (m_cool < 0) begin
      if (sample_valid && rel) m_cool = 0;
    end else if (sample_valid && hit) begin
      m_cool = -1;
    end else if (m_cool == HOLD - 1) begin
      m_active = 0; m_cool = -1;
    end else begin
      m_cool++;
    end
    if (set) begin
      m_irq = 1;
      if (m_count < 65535) m_count++;
    end else if (irq_clear) begin
      m_irq = 0;
    end
  endtask

  function automatic int model_state();
    if (!m_run)       return 0;
    if (!m_active)    return (m_streak > 0) ? 2 : 1;
    if (m_cool < 0)   return 3;
    return 4;
  endfunction

  // -------------------------------------------------------------------------
  // Checking helpers
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic check_out(input string name, input int st, input bit act, input bit irq_e, input int cnt);
    logic [31:0] exp_status;
    exp_status = {cnt[15:0], 11'd0, irq_e, act, st[2:0]};
    check({name, ".status"}, status, exp_status);
    check({name, ".act_en"}, {31'd0, act_en}, {31'd0, act});
    check({name, ".irq"},    {31'd0, irq},    {31'd0, irq_e});
  endtask

  task automatic check_model(input string name);
    check_out(name, model_state(), m_active, m_irq, m_count);
  endtask

  // Drive one cycle of inputs at the falling edge, step the model, and return
  // at the next falling edge where outputs are sampled.
  task automatic cycle(input bit en, input bit inv, input int on_t, input int off_t,
                       input bit valid, input int data, input bit clr);
    cfg_ctrl     = {30'd0, inv, en};
    cfg_thresh   = {off_t[15:0], on_t[15:0]};
    sample_valid = valid;
    sample_data  = data[15:0];
    irq_clear    = clr;
    model_step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESET       = 1'b1;
    cfg_ctrl     = '0;
    cfg_thresh   = '0;
    sample_data  = '0;
    sample_valid = 1'b0;
    irq_clear    = 1'b0;
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    bit rst;
    bit en;
    bit inv;
    int on_t;
    int off_t;
    bit valid;
    int data;
    bit clr;
    int st;
    bit act;
    bit irq_e;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit en, bit inv, int on_t, int off_t, bit valid, int data,
                              bit clr, int st, bit act, bit irq_e, int cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.inv = inv; v.on_t = on_t; v.off_t = off_t;
    v.valid = valid; v.data = data; v.clr = clr;
    v.st = st; v.act = act; v.irq_e = irq_e; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    // Activation after four hits.
    tbl.push_back(mk(0, 1, 0, 100, 80, 0,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 3, 1, 1, 1));
    // A miss inside the debounce run restarts it.
    tbl.push_back(mk(1, 0, 0,   0,  0, 0,   0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 0,   0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1,  50, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 0, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 100, 80, 1, 120, 0, 3, 1, 1, 1));

    // Power-on reset.
    do_reset();
    check_out("reset", 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      else cycle(tbl[i].en, tbl[i].inv, tbl[i].on_t, tbl[i].off_t,
                 tbl[i].valid, tbl[i].data, tbl[i].clr);
      check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].act, tbl[i].irq_e, tbl[i].cnt);
    end

    // Release, then hold for exactly HOLD cycles with no samples.
    cycle(1, 0, 100, 80, 1, 70, 0);
    check_out("t3_release", 4, 1, 1, 1);
    for (int i = 1; i <= HOLD; i++) begin
      cycle(1, 0, 100, 80, 0, 0, 0);
      if (i < HOLD) check_out($sformatf("t3_hold%0d", i), 4, 1, 1, 1);
      else          check_out("t3_expire", 1, 0, 1, 1);
    end

    // Re-activate, clear irq, then hit exactly when the hold expires.
    for (int i = 0; i < DEB_N; i++) cycle(1, 0, 100, 80, 1, 120, 0);
    check_out("t4_active", 3, 1, 1, 2);
    cycle(1, 0, 100, 80, 0, 0, 1);
    check_out("t4_clear", 3, 1, 0, 2);
    cycle(1, 0, 100, 80, 1, 70, 0);
    check_out("t4_cool", 4, 1, 0, 2);
    for (int i = 0; i < HOLD - 1; i++) cycle(1, 0, 100, 80, 0, 0, 0);
    check_out("t4_cool_last", 4, 1, 0, 2);
    cycle(1, 0, 100, 80, 1, 110, 0);
    check_out("t4_reentry", 3, 1, 0, 2);

    // Clear colliding with an activation, then disable and clear later.
    cycle(1, 0, 100, 80, 1, 70, 0);
    for (int i = 0; i < HOLD; i++) cycle(1, 0, 100, 80, 0, 0, 0);
    check_out("t5_armed", 1, 0, 0, 2);
    for (int i = 0; i < DEB_N - 1; i++) cycle(1, 0, 100, 80, 1, 120, 0);
    cycle(1, 0, 100, 80, 1, 120, 1);
    check_out("t5_set_wins", 3, 1, 1, 3);
    cycle(0, 0, 100, 80, 0, 0, 0);
    check_out("t5_disable", 0, 0, 1, 3);
    cycle(0, 0, 100, 80, 0, 0, 1);
    check_out("t5_clear_later", 0, 0, 0, 3);

    // Inverted mode, release threshold clamping and async reset.
    cycle(1, 1, 20, 40, 0, 0, 0);
    check_out("t6_armed", 1, 0, 0, 3);
    for (int i = 0; i < DEB_N; i++) cycle(1, 1, 20, 40, 1, 15, 0);
    check_out("t6_active", 3, 1, 1, 4);
    cycle(1, 1, 20, 40, 1, 30, 0);
    check_out("t6_no_rel", 3, 1, 1, 4);
    cycle(1, 1, 20, 40, 1, 40, 0);
    check_out("t6_rel", 4, 1, 1, 4);
    cycle(1, 1, 20, 40, 1, 15, 0);
    check_out("t6_reentry", 3, 1, 1, 4);
    cycle(1, 1, 20, 10, 1, 19, 0);
    check_out("t6_clamp_hold", 3, 1, 1, 4);
    cycle(1, 1, 20, 10, 1, 20, 0);
    check_out("t6_clamp_rel", 4, 1, 1, 4);
    for (int i = 0; i < 3; i++) cycle(1, 1, 20, 10, 0, 0, 0);
    check_out("t6_mid_cool", 4, 1, 1, 4);
    ARESET = 1'b1;
    model_reset();
    #1;
    check_out("t6_async_rst", 0, 0, 0, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    cycle(1, 1, 20, 10, 0, 0, 0);
    check_out("t6_resume", 1, 0, 0, 0);

    // Randomized run against the model.
    do_reset();
    for (int blk = 0; blk < 40; blk++) begin
      bit inv;
      int on_t, off_t;
      inv   = ($urandom % 4) == 0;
      on_t  = int'($urandom_range(60, 140));
      off_t = int'($urandom_range(0, 200));
      for (int c = 0; c < 50; c++) begin
        cycle(($urandom % 32) != 0, inv, on_t, off_t, ($urandom % 3) != 0,
              int'($urandom_range(0, 200)), ($urandom % 10) == 0);
        check_model($sformatf("rnd%0d_%0d", blk, c));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_decision_engine_core
